// File: rtl/simple_fetch_stage.sv
// Fetch stage: PC generation, 1-cycle-latency imem interface, 2-entry output FIFO, WAIT halt.
// Perf counters (fetch_count_o, stall_count_o) are built only when SIMPLE_FETCH_PERF_EN is defined.
module simple_fetch_stage #(
  parameter int unsigned IMEM_ADDR_W = 10,
  parameter int unsigned PC_RESET    = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imem_req_o,
  output logic [IMEM_ADDR_W-1:0] imem_addr_o,
  input  logic [15:0]            imem_data_i,
  output logic [15:0]            instr_o,
  output logic                   instr_valid_o,
  input  logic                   instr_ready_i,
  output logic [IMEM_ADDR_W-1:0] instr_pc_o,
  input  logic                   stop_i,
  input  logic                   restart_i,
  output logic                   halted_o,
  output logic [31:0]            fetch_count_o,
  output logic [31:0]            stall_count_o
);

  localparam logic [IMEM_ADDR_W-1:0] PC_INIT = IMEM_ADDR_W'(PC_RESET);
  localparam logic [IMEM_ADDR_W-1:0] PC_ONE  = IMEM_ADDR_W'(1);

  typedef enum logic {ST_RUN, ST_HALT} state_e;

  state_e                 state;
  logic [IMEM_ADDR_W-1:0] pc;
  logic [IMEM_ADDR_W-1:0] req_pc;
  logic                   inflight;
  logic [1:0]             fifo_count;
  logic [15:0]            data0, data1;
  logic [IMEM_ADDR_W-1:0] pc0, pc1;
  logic                   transfer;
  logic                   halt_now;
  logic [2:0]             occupancy;

  // Entry 0 is the FIFO head and drives the execute-stage interface directly.
  assign instr_valid_o = (fifo_count != 2'd0);
  assign instr_o       = data0;
  assign instr_pc_o    = pc0;
  assign imem_addr_o   = pc;
  assign halted_o      = (state == ST_HALT);

  assign transfer  = instr_valid_o & instr_ready_i;
  assign halt_now  = transfer & stop_i;
  assign occupancy = 3'(fifo_count) + 3'(inflight);

  // Credit rule: a slot freed by this cycle's transfer may be re-requested immediately.
  assign imem_req_o = ~reset & (state == ST_RUN) &
                      (occupancy < (transfer ? 3'd3 : 3'd2));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_RUN;
      pc         <= PC_INIT;
      req_pc     <= '0;
      inflight   <= 1'b0;
      fifo_count <= 2'd0;
      data0      <= '0;
      data1      <= '0;
      pc0        <= '0;
      pc1        <= '0;
    end else if (state == ST_RUN) begin
      if (halt_now) begin
        // WAIT accepted: flush, drop the in-flight word, resume after the WAIT.
        state      <= ST_HALT;
        pc         <= pc0 + PC_ONE;
        inflight   <= 1'b0;
        fifo_count <= 2'd0;
      end else begin
        if (imem_req_o) begin
          pc     <= pc + PC_ONE;
          req_pc <= pc;
        end
        inflight <= imem_req_o;
        case ({inflight, transfer})
          2'b01: begin
            data0      <= data1;
            pc0        <= pc1;
            fifo_count <= fifo_count - 2'd1;
          end
          2'b10: begin
            if (fifo_count == 2'd0) begin
              data0 <= imem_data_i;
              pc0   <= req_pc;
            end else begin
              data1 <= imem_data_i;
              pc1   <= req_pc;
            end
            fifo_count <= fifo_count + 2'd1;
          end
          2'b11: begin
            if (fifo_count == 2'd1) begin
              data0 <= imem_data_i;
              pc0   <= req_pc;
            end else begin
              data0 <= data1;
              pc0   <= pc1;
              data1 <= imem_data_i;
              pc1   <= req_pc;
            end
          end
          default: ;
        endcase
      end
    end else if (restart_i) begin
      state <= ST_RUN;
    end
  end

`ifdef SIMPLE_FETCH_PERF_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count <= 32'h0;
      stall_count <= 32'h0;
    end else begin
      if (transfer)
        fetch_count <= fetch_count + 32'd1;
      if (instr_valid_o && !instr_ready_i && state == ST_RUN)
        stall_count <= stall_count + 32'd1;
    end
  end

  assign fetch_count_o = fetch_count;
  assign stall_count_o = stall_count;
`else
  assign fetch_count_o = 32'h0;
  assign stall_count_o = 32'h0;
`endif

endmodule

// File: tb/tb_simple_fetch_stage.sv
// Randomized self-checking bench for simple_fetch_stage against a sequence-level reference model.
// A second instance (4-bit PC, reset at 14) exercises address wrap.
module tb_simple_fetch_stage;
  localparam int unsigned W  = 10;
  localparam int unsigned WW = 4;

  logic          clk;
  logic          reset;
  logic          imem_req_o;
  logic [W-1:0]  imem_addr_o;
  logic [15:0]   imem_data_i;
  logic [15:0]   instr_o;
  logic          instr_valid_o;
  logic          instr_ready_i;
  logic [W-1:0]  instr_pc_o;
  logic          stop_i;
  logic          restart_i;
  logic          halted_o;
  logic [31:0]   fetch_count_o;
  logic [31:0]   stall_count_o;

  logic          w_req, w_valid, w_halted;
  logic [WW-1:0] w_addr, w_pc;
  logic [15:0]   w_data, w_instr;
  logic [31:0]   w_fcnt, w_scnt;
  logic          w_ready, w_stop, w_restart;

  simple_fetch_stage dut (
    .clk(clk), .reset(reset), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_data_i(imem_data_i), .instr_o(instr_o), .instr_valid_o(instr_valid_o),
    .instr_ready_i(instr_ready_i), .instr_pc_o(instr_pc_o), .stop_i(stop_i),
    .restart_i(restart_i), .halted_o(halted_o), .fetch_count_o(fetch_count_o),
    .stall_count_o(stall_count_o)
  );

  simple_fetch_stage #(.IMEM_ADDR_W(WW), .PC_RESET(14)) u_wrap (
    .clk(clk), .reset(reset), .imem_req_o(w_req), .imem_addr_o(w_addr),
    .imem_data_i(w_data), .instr_o(w_instr), .instr_valid_o(w_valid),
    .instr_ready_i(w_ready), .instr_pc_o(w_pc), .stop_i(w_stop),
    .restart_i(w_restart), .halted_o(w_halted), .fetch_count_o(w_fcnt),
    .stall_count_o(w_scnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: instruction stream is sequential from PC_RESET, restarting after each WAIT.
  logic [W-1:0]  exp_fetch_pc, exp_req_pc, last_req_addr;
  logic          last_req, halted_m, prev_rst;
  int            outstanding, invalid_run;
  logic [31:0]   fetch_m, stall_m;
  logic [WW-1:0] w_exp_req, w_exp_f, w_last_addr;
  logic          w_last_req;
  int            w_seen;
  logic [WW-1:0] w_log [4];

  logic          obs_valid, obs_req, obs_halted;
  logic [W-1:0]  obs_addr, obs_pc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [15:0] mem_word(input logic [31:0] a);
    return 16'(a * 32'd40503 + 32'd7);
  endfunction

  function automatic logic [31:0] perf(input logic [31:0] v);
`ifdef SIMPLE_FETCH_PERF_EN
    return v;
`else
    return v & 32'h0;
`endif
  endfunction

  task automatic cycle(input logic rdy, input logic stp, input logic rst_pulse, input logic rst_in);
    logic xfer;
    @(negedge clk);
    instr_ready_i = rdy;
    stop_i        = stp;
    restart_i     = rst_pulse;
    reset         = rst_in;
    imem_data_i   = last_req ? mem_word(32'(last_req_addr)) : 16'($urandom);
    w_data        = w_last_req ? mem_word(32'(w_last_addr)) : 16'($urandom);
    #1;
    obs_valid = instr_valid_o; obs_req = imem_req_o; obs_halted = halted_o;
    obs_addr = imem_addr_o; obs_pc = instr_pc_o;
    if (rst_in) begin
      if (prev_rst) begin
        check_eq("rst_req", 32'(imem_req_o), 32'd0);
        check_eq("rst_addr", 32'(imem_addr_o), 32'd0);
        check_eq("rst_valid", 32'(instr_valid_o), 32'd0);
        check_eq("rst_instr", 32'(instr_o), 32'd0);
        check_eq("rst_pc", 32'(instr_pc_o), 32'd0);
        check_eq("rst_halted", 32'(halted_o), 32'd0);
        check_eq("rst_fcnt", fetch_count_o, 32'd0);
        check_eq("rst_scnt", stall_count_o, 32'd0);
        check_eq("rst_waddr", 32'(w_addr), 32'd14);
      end
      exp_fetch_pc = '0; exp_req_pc = '0; last_req = 1'b0; halted_m = 1'b0;
      outstanding = 0; invalid_run = 0; fetch_m = '0; stall_m = '0;
      w_exp_req = 4'd14; w_exp_f = 4'd14; w_last_req = 1'b0; w_seen = 0;
      prev_rst = 1'b1;
    end else begin
      prev_rst = 1'b0;
      xfer = instr_valid_o & rdy;
      check_eq("halted", 32'(halted_o), 32'(halted_m));
      check_eq("fetch_cnt", fetch_count_o, perf(fetch_m));
      check_eq("stall_cnt", stall_count_o, perf(stall_m));
      if (halted_m) begin
        check_eq("halt_req", 32'(imem_req_o), 32'd0);
        check_eq("halt_valid", 32'(instr_valid_o), 32'd0);
      end
      if (imem_req_o) begin
        check_eq("req_addr", 32'(imem_addr_o), 32'(exp_req_pc));
        check_eq("credit", 32'((outstanding + 1 - int'(xfer)) <= 2), 32'd1);
      end
      if (instr_valid_o) begin
        check_eq("instr_pc", 32'(instr_pc_o), 32'(exp_fetch_pc));
        check_eq("instr_data", 32'(instr_o), 32'(mem_word(32'(exp_fetch_pc))));
        invalid_run = 0;
      end else if (!halted_m) begin
        invalid_run++;
        check_eq("liveness", 32'(invalid_run <= 2), 32'd1);
      end
      if (w_req) begin
        check_eq("wrap_addr", 32'(w_addr), 32'(w_exp_req));
        if (w_seen < 4) w_log[w_seen] = w_addr;
        w_seen++;
        w_exp_req = w_exp_req + 4'd1;
      end
      if (w_valid) begin
        check_eq("wrap_pc", 32'(w_pc), 32'(w_exp_f));
        check_eq("wrap_data", 32'(w_instr), 32'(mem_word(32'(w_exp_f))));
        w_exp_f = w_exp_f + 4'd1;
      end
      w_last_req = w_req; w_last_addr = w_addr;
      if (instr_valid_o && !rdy && !halted_m) stall_m = stall_m + 32'd1;
      if (xfer) begin
        fetch_m = fetch_m + 32'd1; exp_fetch_pc = exp_fetch_pc + 1'b1; outstanding--;
      end
      if (imem_req_o) begin
        exp_req_pc = exp_req_pc + 1'b1; outstanding++;
      end
      last_req = imem_req_o; last_req_addr = imem_addr_o;
      if (xfer && stp) begin
        halted_m = 1'b1; exp_req_pc = exp_fetch_pc; outstanding = 0;
        last_req = 1'b0; invalid_run = 0;
      end else if (halted_m && rst_pulse) begin
        halted_m = 1'b0; invalid_run = 0;
      end
    end
    @(posedge clk);
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    int first_v;
    int reqs;
    logic [W-1:0] first_pc;
    reset = 1'b1; instr_ready_i = 1'b0; stop_i = 1'b0; restart_i = 1'b0;
    imem_data_i = '0; w_data = '0; w_ready = 1'b1; w_stop = 1'b0; w_restart = 1'b0;
    last_req = 1'b0; w_last_req = 1'b0; prev_rst = 1'b0; halted_m = 1'b0;
    exp_fetch_pc = '0; exp_req_pc = '0; last_req_addr = '0; outstanding = 0; invalid_run = 0;
    fetch_m = '0; stall_m = '0; w_exp_req = 4'd14; w_exp_f = 4'd14; w_last_addr = '0; w_seen = 0;

    // Free run: latency and wrap sequence of the 4-bit instance.
    do_reset();
    first_v = -1;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      if (obs_valid && first_v < 0) first_v = i;
    end
    check_eq("first_valid_cycle", 32'(first_v), 32'd2);
    for (int i = 0; i < 4; i++)
      check_eq("wrap_seq", 32'(w_log[i]), 32'((14 + i) % 16));

    // Backpressure: 5 stalled cycles right after the first valid.
    do_reset();
    reqs = 0;
    for (int i = 0; i < 7; i++) begin
      cycle(i < 2, 1'b0, 1'b0, 1'b0);
      if (obs_req) reqs++;
      if (i >= 2) check_eq("stall_hold", 32'(obs_pc), 32'd0);
    end
    check_eq("stall_reqs", 32'(reqs), 32'd2);
    #1;
    check_eq("stall_cnt5", stall_count_o, perf(32'd5));
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);

    // WAIT accepted at pc 3, then restart.
    do_reset();
    for (int i = 0; i < 20 && !halted_m; i++)
      cycle(1'b1, exp_fetch_pc == W'(3), 1'b0, 1'b0);
    check_eq("wait_reached", 32'(halted_m), 32'd1);
    check_eq("wait_cycle_req", 32'(obs_req), 32'd1);
    check_eq("wait_cycle_addr", 32'(obs_addr), 32'd5);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      check_eq("halt_flag", 32'(obs_halted), 32'd1);
    end
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("restart_req", 32'(obs_req), 32'd1);
    check_eq("restart_addr", 32'(obs_addr), 32'd4);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);

    // Reset while the FIFO is loaded and a response is in flight.
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("preflush_req", 32'(obs_req), 32'd1);
    do_reset();
    first_pc = '1;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      if (obs_valid && first_pc == '1) first_pc = obs_pc;
    end
    check_eq("post_reset_pc", 32'(first_pc), 32'd0);

    // Randomized traffic with backpressure, WAITs, stray restarts and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 3) == 0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
